hazard_scoreboard: RTL

Parametrised successor to the pipeline hazard unit. Adds a register scoreboard for long-latency operations (multi-cycle mul/div, outstanding loads), N-stage generalised forwarding, structural stalls on scoreboard full, and optional stall-cycle performance counters. It sits beside the 5-stage pipeline and drives all IF/ID, ID/EX, EX/MEM and MEM/WB stall/flush controls plus the ID/EX forward selects.

---
 rtl/hazard_scoreboard.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - 5-stage pipeline hazard unit with a long-latency register scoreboard
// Optional stall-cycle counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_scoreboard #(
   parameter  int NUM_FWD_STAGES = 2,
   parameter  int SB_DEPTH       = 4,
   parameter  int PERF_CNT_W     = 32,
   localparam int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic [4:0]                  id_rs1_addr_i,
   input  logic [4:0]                  id_rs2_addr_i,
   input  logic [4:0]                  id_rd_addr_i,
   input  logic                        id_rd_write_i,
   input  logic [4:0]                  ex_rs1_addr_i,
   input  logic [4:0]                  ex_rs2_addr_i,
   input  logic [4:0]                  ex_rd_addr_i,
   input  logic                        ex_is_mem_read_i,
   input  logic                        ex_long_issue_i,
   input  logic [5*NUM_FWD_STAGES-1:0] fwd_rd_addr_i,
   input  logic [NUM_FWD_STAGES-1:0]   fwd_rd_write_i,
   input  logic                        long_done_i,
   input  logic                        mem_req_i,
   input  logic                        mem_done_i,
   input  logic                        redirect_i,
   input  logic                        ex_trap_valid_i,
   input  logic                        mem_trap_valid_i,
   input  logic                        wb_trap_valid_i,
   output logic                        id_forward_a_o,
   output logic                        id_forward_b_o,
   output logic [SEL_W-1:0]            ex_forward_a_sel_o,
   output logic [SEL_W-1:0]            ex_forward_b_sel_o,
   output logic                        if_id_stall_o,
   output logic                        id_ex_stall_o,
   output logic                        ex_mem_stall_o,
   output logic                        mem_wb_stall_o,
   output logic                        if_id_flush_o,
   output logic                        id_ex_flush_o,
   output logic                        ex_mem_flush_o,
   output logic                        mem_wb_flush_o,
`ifdef HAZARD_PERF_CNT_EN
   output logic [PERF_CNT_W-1:0]       perf_load_use_o,
   output logic [PERF_CNT_W-1:0]       perf_sb_stall_o,
   output logic [PERF_CNT_W-1:0]       perf_mem_stall_o,
`endif
   output logic                        sb_full_o,
   output logic                        sb_empty_o,
   output logic                        sb_err_o
);

   localparam int PTR_W = $clog2(SB_DEPTH);
   localparam int LAST  = NUM_FWD_STAGES - 1;

   if (NUM_FWD_STAGES < 1 || NUM_FWD_STAGES > 4 || SB_DEPTH < 2 || SB_DEPTH > 16 ||
       (SB_DEPTH & (SB_DEPTH - 1)) != 0 || PERF_CNT_W < 1) begin : g_param_check
      $error("hazard_scoreboard: illegal parameter value");
   end

   logic [31:0]      pending;
   logic [31:0]      pending_next;
   logic [4:0]       rd_fifo [SB_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             sb_err;

   logic load_use, sb_raw, sb_waw, sb_struct, mem_stall;
   logic issue_ok, push, pop;

   assign sb_full_o  = (count == (PTR_W + 1)'(SB_DEPTH));
   assign sb_empty_o = (count == '0);
   assign sb_err_o   = sb_err;

   assign mem_stall      = mem_req_i && !mem_done_i;
   assign mem_wb_stall_o = mem_stall;
   assign ex_mem_stall_o = mem_stall || mem_wb_stall_o;
   assign id_ex_stall_o  = ex_mem_stall_o || sb_struct;
   assign if_id_stall_o  = id_ex_stall_o || load_use || sb_raw || sb_waw;

   assign issue_ok  = ex_long_issue_i && !sb_full_o && !ex_mem_stall_o;
   assign push      = issue_ok && (ex_rd_addr_i != 5'd0);
   assign pop       = long_done_i && !sb_empty_o;
   assign sb_struct = ex_long_issue_i && sb_full_o;

   assign load_use = ex_is_mem_read_i &&
                     (((id_rs1_addr_i != 5'd0) && (id_rs1_addr_i == ex_rd_addr_i)) ||
                      ((id_rs2_addr_i != 5'd0) && (id_rs2_addr_i == ex_rd_addr_i)));

   // An issue accepted this cycle is not in pending yet, so match it directly.
   assign sb_raw = ((id_rs1_addr_i != 5'd0) &&
                    (pending[id_rs1_addr_i] || (issue_ok && (ex_rd_addr_i == id_rs1_addr_i)))) ||
                   ((id_rs2_addr_i != 5'd0) &&
                    (pending[id_rs2_addr_i] || (issue_ok && (ex_rd_addr_i == id_rs2_addr_i))));

   assign sb_waw = id_rd_write_i && (id_rd_addr_i != 5'd0) && pending[id_rd_addr_i];

   assign if_id_flush_o  = redirect_i || ex_trap_valid_i || mem_trap_valid_i || wb_trap_valid_i;
   assign id_ex_flush_o  = (if_id_stall_o && !id_ex_stall_o) || redirect_i ||
                           mem_trap_valid_i || wb_trap_valid_i;
   assign ex_mem_flush_o = (id_ex_stall_o && !ex_mem_stall_o) || (redirect_i && !ex_mem_stall_o) ||
                           mem_trap_valid_i || wb_trap_valid_i;
   assign mem_wb_flush_o = (ex_mem_stall_o && !mem_wb_stall_o) || wb_trap_valid_i;

   assign id_forward_a_o = fwd_rd_write_i[LAST] && (id_rs1_addr_i != 5'd0) &&
                           (fwd_rd_addr_i[5*LAST +: 5] == id_rs1_addr_i);
   assign id_forward_b_o = fwd_rd_write_i[LAST] && (id_rs2_addr_i != 5'd0) &&
                           (fwd_rd_addr_i[5*LAST +: 5] == id_rs2_addr_i);

   // Walk oldest to youngest so the youngest matching stage is the one left standing.
   always_comb begin
      ex_forward_a_sel_o = '0;
      ex_forward_b_sel_o = '0;
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
         if (fwd_rd_write_i[k] && (ex_rs1_addr_i != 5'd0) && (fwd_rd_addr_i[5*k +: 5] == ex_rs1_addr_i))
            ex_forward_a_sel_o = SEL_W'(k + 1);
         if (fwd_rd_write_i[k] && (ex_rs2_addr_i != 5'd0) && (fwd_rd_addr_i[5*k +: 5] == ex_rs2_addr_i))
            ex_forward_b_sel_o = SEL_W'(k + 1);
      end
   end

   always_comb begin
      pending_next = pending;
      if (pop)
         pending_next[rd_fifo[rd_ptr]] = 1'b0;
      if (push)
         pending_next[ex_rd_addr_i] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (push)
         rd_fifo[wr_ptr] <= ex_rd_addr_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         pending <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         sb_err  <= 1'b0;
      end else if (wb_trap_valid_i) begin
         pending <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else begin
         pending <= pending_next;
         if (long_done_i && sb_empty_o)
            sb_err <= 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] cnt_load_use, cnt_sb_stall, cnt_mem_stall;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_load_use  <= '0;
         cnt_sb_stall  <= '0;
         cnt_mem_stall <= '0;
      end else begin
         if (load_use && (cnt_load_use != '1))
            cnt_load_use <= cnt_load_use + 1'b1;
         if ((sb_raw || sb_waw || sb_struct) && (cnt_sb_stall != '1))
            cnt_sb_stall <= cnt_sb_stall + 1'b1;
         if (mem_stall && (cnt_mem_stall != '1))
            cnt_mem_stall <= cnt_mem_stall + 1'b1;
      end
   end

   assign perf_load_use_o  = cnt_load_use;
   assign perf_sb_stall_o  = cnt_sb_stall;
   assign perf_mem_stall_o = cnt_mem_stall;
`endif

endmodule
